// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Scan controller for a common-anode multi-digit 7-segment display. One
// external BCD-to-7-segment decoder is shared by all digits. Each digit is
// shown in two phases:
//   BLANK : anodes dark, the digit's BCD value is sent to the decoder
//   DRIVE : the latched segments are shown with the digit's anode low
// The BLANK phase is the dead time between digits that suppresses ghosting.
//
// Ports
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : scan enable; low forces IDLE with the display dark
//   load        : one-cycle strobe; captures digits_in into the pending frame
//   digits_in   : BCD digits, digit k = bits [4k+3:4k], digit 0 rightmost
//   lzb         : leading-zero blanking enable
//   bcd_out     : BCD value to the shared decoder
//   seg_in      : decoder output (a..g), combinational from bcd_out
//   seg_out     : registered segments to the display
//   an_n        : active-low anode enables, at most one low
//   frame_done  : one-cycle pulse on the last DRIVE cycle of the last digit
//   busy        : high whenever the FSM is not in IDLE
//   dbg_state   : current FSM state (0 IDLE, 1 BLANK, 2 DRIVE)
//
// Input strobe semantics: load is sampled on every rising edge while rst_n is
// high. A high sample copies digits_in into the pending frame. There is no
// back-pressure; the pending frame is only copied into the displayed frame
// at a frame start, so the displayed frame never changes mid-frame.
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int DEAD_CYC    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    lzb,
    output logic [3:0]              bcd_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    localparam int DW      = 4 * NUM_DIGITS;
    localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     pending_q, pending_d;
    logic [DW-1:0]     active_q, active_d;
    logic [6:0]        seg_q, seg_d;
    logic              frame_start;
    logic              frame_done_d;

    logic [NUM_DIGITS-1:0] zero_from;
    logic                  zero_acc;
    logic [3:0]            cur_digit;
    logic                  digit_blanked;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            active_q  <= '0;
            seg_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            seg_q     <= seg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        seg_d        = seg_q;
        active_d     = active_q;
        pending_d    = load ? digits_in : pending_q;
        frame_start  = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                seg_d = '0;
                if (en) begin
                    state_d     = BLANK;
                    frame_start = 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    // bcd_out has been stable for the whole BLANK phase here
                    cnt_d   = '0;
                    seg_d   = seg_in;
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_start  = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load in the frame-start cycle bypasses pending so it is not lost
        if (frame_start) begin
            active_d = load ? digits_in : pending_q;
        end

        if (!en) begin
            state_d      = IDLE;
            idx_d        = '0;
            cnt_d        = '0;
            seg_d        = '0;
            active_d     = active_q;
            frame_done_d = 1'b0;
        end
    end

    // zero_from[k] is set when digits k..NUM_DIGITS-1 of the frame are all 0
    always_comb begin
        zero_acc  = 1'b1;
        zero_from = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_acc     = zero_acc & (active_q[4*k +: 4] == 4'd0);
            zero_from[k] = zero_acc;
        end
    end

    assign cur_digit     = active_q[4*idx_q +: 4];
    assign digit_blanked = lzb && (idx_q != '0) && zero_from[idx_q];

    always_comb begin
        an_n = '1;
        if (state_q == DRIVE && !digit_blanked) begin
            an_n[idx_q] = 1'b0;
        end
    end

    assign bcd_out    = (state_q == IDLE) ? 4'd0 : cur_digit;
    assign seg_out    = seg_q;
    assign frame_done = frame_done_d;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYC=1.
// The reference model tracks the scan as a cycle count since the scan
// started: position in frame, digit and phase follow from division by the
// digit period, independent of any FSM encoding. A 7-segment decoder table
// drives seg_in from bcd_out.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int DC    = 1;
    localparam int DIG   = DC + RD;
    localparam int FRAME = ND * DIG;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic        lzb;
    logic [3:0]  bcd_out;
    logic [6:0]  seg_in;
    logic [6:0]  seg_out;
    logic [3:0]  an_n;
    logic        frame_done;
    logic        busy;
    logic [1:0]  dbg_state;

    logic [6:0] seg_tbl [16];

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_run;
    int          m_t;
    logic [15:0] m_pending;
    logic [15:0] m_active;
    logic [6:0]  m_seg;

    // expected outputs after the latest edge
    logic [3:0] e_bcd;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_fd;
    logic       e_busy;
    int         e_dig;
    bit         e_drive;

    always #5 clk = ~clk;

    assign seg_in = seg_tbl[bcd_out];

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYC   (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .digits_in (digits_in),
        .lzb       (lzb),
        .bcd_out   (bcd_out),
        .seg_in    (seg_in),
        .seg_out   (seg_out),
        .an_n      (an_n),
        .frame_done(frame_done),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // at most one anode low, every cycle of the run
    always @(negedge clk) begin
        total++;
        if ($countones(~an_n) > 1) begin
            bad++;
            $display("FAIL an_onehot time=%0t got=%b required=at most one low", $time, an_n);
        end
    end

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        return v[4*k +: 4];
    endfunction

    function automatic bit lz_blanked(input int k);
        if (!lzb || k == 0) return 1'b0;
        for (int j = k; j < ND; j++) begin
            if (nib(m_active, j) != 4'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic calc_expected();
        int pos;
        e_an    = 4'hF;
        e_fd    = 1'b0;
        e_busy  = m_run;
        e_seg   = m_seg;
        e_bcd   = 4'd0;
        e_drive = 1'b0;
        e_dig   = 0;
        if (m_run) begin
            pos     = m_t % FRAME;
            e_dig   = pos / DIG;
            e_drive = (pos % DIG) >= DC;
            e_bcd   = nib(m_active, e_dig);
            if (e_drive && !lz_blanked(e_dig)) e_an[e_dig] = 1'b0;
            e_fd = e_drive && (pos == FRAME - 1);
        end
    endtask

    // one clock: update the model with the inputs seen at the edge, then
    // move to the falling edge where outputs are compared
    task automatic step();
        logic [15:0] nxt_pend;
        @(posedge clk);
        if (!rst_n) begin
            m_run     = 1'b0;
            m_t       = 0;
            m_pending = '0;
            m_active  = '0;
            m_seg     = '0;
        end else begin
            nxt_pend = load ? digits_in : m_pending;
            if (!en) begin
                m_run = 1'b0;
                m_seg = '0;
            end else begin
                if (!m_run) begin
                    m_run    = 1'b1;
                    m_t      = 0;
                    m_active = nxt_pend;
                end else begin
                    m_t++;
                    if (m_t % FRAME == 0) m_active = nxt_pend;
                end
                if (m_t % DIG == DC) m_seg = seg_tbl[nib(m_active, (m_t % FRAME) / DIG)];
            end
            m_pending = nxt_pend;
        end
        @(negedge clk);
        calc_expected();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; load = 1'b0; digits_in = 16'h0; lzb = 1'b0;
        repeat (3) begin
            step();
            total += 5;
            if (an_n !== e_an) begin bad++; $display("FAIL reset_an got=%b exp=%b", an_n, e_an); end
            if (seg_out !== e_seg) begin bad++; $display("FAIL reset_seg got=%h exp=%h", seg_out, e_seg); end
            if (busy !== e_busy) begin bad++; $display("FAIL reset_busy got=%b exp=%b", busy, e_busy); end
            if (frame_done !== e_fd) begin bad++; $display("FAIL reset_fd got=%b exp=%b", frame_done, e_fd); end
            if (bcd_out !== e_bcd) begin bad++; $display("FAIL reset_bcd got=%h exp=%h", bcd_out, e_bcd); end
        end
    endtask

    task automatic test_basic_scan();
        int fd_cnt = 0;
        rst_n = 1'b1; en = 1'b0;
        step();
        load = 1'b1; digits_in = 16'h1234;
        step();
        load = 1'b0; en = 1'b1;
        repeat (2 * FRAME) begin
            step();
            if (frame_done === 1'b1) fd_cnt++;
            total += 5;
            if (an_n !== e_an) begin bad++; $display("FAIL basic_an t=%0d got=%b exp=%b", m_t, an_n, e_an); end
            if (seg_out !== e_seg) begin bad++; $display("FAIL basic_seg t=%0d got=%h exp=%h", m_t, seg_out, e_seg); end
            if (bcd_out !== e_bcd) begin bad++; $display("FAIL basic_bcd t=%0d got=%h exp=%h", m_t, bcd_out, e_bcd); end
            if (frame_done !== e_fd) begin bad++; $display("FAIL basic_fd t=%0d got=%b exp=%b", m_t, frame_done, e_fd); end
            if (busy !== e_busy) begin bad++; $display("FAIL basic_busy t=%0d got=%b exp=%b", m_t, busy, e_busy); end
        end
        total++;
        if (fd_cnt != 2) begin bad++; $display("FAIL basic_fd_count got=%0d exp=2", fd_cnt); end
    endtask

    task automatic test_no_tearing();
        int k;
        int guard;
        // frame start, then a load somewhere mid-frame
        step();
        k = $urandom_range(2, 15);
        repeat (k) step();
        load = 1'b1; digits_in = 16'h5678;
        step();
        load = 1'b0;
        // rest of this frame must still show 1234
        while ((m_t % FRAME) != 0) begin
            total += 3;
            if (bcd_out < 4'd1 || bcd_out > 4'd4) begin bad++; $display("FAIL tear_old_frame t=%0d got=%h exp=1..4", m_t, bcd_out); end
            if (an_n !== e_an) begin bad++; $display("FAIL tear_an t=%0d got=%b exp=%b", m_t, an_n, e_an); end
            if (seg_out !== e_seg) begin bad++; $display("FAIL tear_seg t=%0d got=%h exp=%h", m_t, seg_out, e_seg); end
            step();
        end
        // next frame shows 5678
        guard = 0;
        while ((m_t % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
            total += 3;
            if (bcd_out < 4'd5 || bcd_out > 4'd8) begin bad++; $display("FAIL tear_new_frame t=%0d got=%h exp=5..8", m_t, bcd_out); end
            if (an_n !== e_an) begin bad++; $display("FAIL tear_an2 t=%0d got=%b exp=%b", m_t, an_n, e_an); end
            if (seg_out !== e_seg) begin bad++; $display("FAIL tear_seg2 t=%0d got=%h exp=%h", m_t, seg_out, e_seg); end
            step();
            guard++;
        end
        // load in the frame-start cycle is taken by that very frame
        load = 1'b1; digits_in = 16'h4321;
        step();
        load = 1'b0;
        total += 2;
        if (bcd_out !== 4'd1) begin bad++; $display("FAIL tear_same_cycle_load got=%h exp=1", bcd_out); end
        if (bcd_out !== e_bcd) begin bad++; $display("FAIL tear_same_cycle_model got=%h exp=%h", bcd_out, e_bcd); end
        repeat (FRAME) begin
            step();
            total += 3;
            if (an_n !== e_an) begin bad++; $display("FAIL tear_an3 t=%0d got=%b exp=%b", m_t, an_n, e_an); end
            if (seg_out !== e_seg) begin bad++; $display("FAIL tear_seg3 t=%0d got=%h exp=%h", m_t, seg_out, e_seg); end
            if (frame_done !== e_fd) begin bad++; $display("FAIL tear_fd t=%0d got=%b exp=%b", m_t, frame_done, e_fd); end
        end
    endtask

    task automatic test_lzb();
        logic [15:0] pats [2];
        bit exp_lit;
        pats[0] = 16'h0040;
        pats[1] = 16'h0000;
        lzb = 1'b1;
        for (int p = 0; p < 2; p++) begin
            load = 1'b1; digits_in = pats[p];
            step();
            load = 1'b0;
            repeat (2 * FRAME) begin
                step();
                total += 3;
                if (an_n !== e_an) begin bad++; $display("FAIL lzb_an t=%0d got=%b exp=%b", m_t, an_n, e_an); end
                if (bcd_out !== e_bcd) begin bad++; $display("FAIL lzb_bcd t=%0d got=%h exp=%h", m_t, bcd_out, e_bcd); end
                if (seg_out !== e_seg) begin bad++; $display("FAIL lzb_seg t=%0d got=%h exp=%h", m_t, seg_out, e_seg); end
                if (e_drive && m_active == pats[p]) begin
                    exp_lit = (p == 0) ? (e_dig <= 1) : (e_dig == 0);
                    total++;
                    if ((an_n != 4'hF) !== exp_lit) begin
                        bad++;
                        $display("FAIL lzb_lit pat=%h digit=%0d got_an=%b exp_lit=%0d", pats[p], e_dig, an_n, exp_lit);
                    end
                end
            end
        end
        lzb = 1'b0;
    endtask

    task automatic test_en_drop();
        int target;
        int guard = 0;
        load = 1'b1; digits_in = 16'h9876;
        step();
        load = 1'b0;
        target = 2 * DIG + DC + $urandom_range(0, RD - 1);
        while ((m_t % FRAME) != target && guard < 3 * FRAME) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 3 * FRAME) begin bad++; $display("FAIL endrop_reach got=timeout exp=digit2 drive"); end
        en = 1'b0;
        repeat (3) begin
            step();
            total += 5;
            if (busy !== 1'b0) begin bad++; $display("FAIL endrop_busy got=%b exp=0", busy); end
            if (an_n !== 4'hF) begin bad++; $display("FAIL endrop_an got=%b exp=1111", an_n); end
            if (seg_out !== 7'h0) begin bad++; $display("FAIL endrop_seg got=%h exp=0", seg_out); end
            if (frame_done !== 1'b0) begin bad++; $display("FAIL endrop_fd got=%b exp=0", frame_done); end
            if (dbg_state !== 2'd0) begin bad++; $display("FAIL endrop_state got=%0d exp=0", dbg_state); end
        end
        en = 1'b1;
        step();
        total += 3;
        if (busy !== 1'b1) begin bad++; $display("FAIL reen_busy got=%b exp=1", busy); end
        if (an_n !== 4'hF) begin bad++; $display("FAIL reen_blank_an got=%b exp=1111", an_n); end
        if (bcd_out !== e_bcd) begin bad++; $display("FAIL reen_bcd got=%h exp=%h", bcd_out, e_bcd); end
        step();
        total += 2;
        if (an_n !== 4'b1110) begin bad++; $display("FAIL reen_digit0 got=%b exp=1110", an_n); end
        if (seg_out !== e_seg) begin bad++; $display("FAIL reen_seg got=%h exp=%h", seg_out, e_seg); end
    endtask

    task automatic test_invalid_bcd();
        bit seen_f = 1'b0;
        bit seen_a = 1'b0;
        lzb = 1'b0;
        load = 1'b1; digits_in = 16'hFA00;
        step();
        load = 1'b0;
        repeat (2 * FRAME) begin
            step();
            if (bcd_out === 4'hF) seen_f = 1'b1;
            if (bcd_out === 4'hA) seen_a = 1'b1;
            total += 3;
            if (bcd_out !== e_bcd) begin bad++; $display("FAIL badbcd_bcd t=%0d got=%h exp=%h", m_t, bcd_out, e_bcd); end
            if (seg_out !== e_seg) begin bad++; $display("FAIL badbcd_seg t=%0d got=%h exp=%h", m_t, seg_out, e_seg); end
            if (an_n !== e_an) begin bad++; $display("FAIL badbcd_an t=%0d got=%b exp=%b", m_t, an_n, e_an); end
        end
        total += 2;
        if (!seen_f) begin bad++; $display("FAIL badbcd_seen_15 got=0 exp=1"); end
        if (!seen_a) begin bad++; $display("FAIL badbcd_seen_10 got=0 exp=1"); end
    endtask

    task automatic test_random();
        logic [15:0] masks [5];
        masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
        masks[3] = 16'h000F; masks[4] = 16'h0000;
        repeat (400) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            en        = ($urandom_range(0, 49) != 0);
            load      = ($urandom_range(0, 9) == 0);
            digits_in = 16'($urandom) & masks[$urandom_range(0, 4)];
            if ($urandom_range(0, 19) == 0) lzb = ~lzb;
            step();
            total += 5;
            if (an_n !== e_an) begin bad++; $display("FAIL rand_an t=%0d got=%b exp=%b", m_t, an_n, e_an); end
            if (seg_out !== e_seg) begin bad++; $display("FAIL rand_seg t=%0d got=%h exp=%h", m_t, seg_out, e_seg); end
            if (bcd_out !== e_bcd) begin bad++; $display("FAIL rand_bcd t=%0d got=%h exp=%h", m_t, bcd_out, e_bcd); end
            if (frame_done !== e_fd) begin bad++; $display("FAIL rand_fd t=%0d got=%b exp=%b", m_t, frame_done, e_fd); end
            if (busy !== e_busy) begin bad++; $display("FAIL rand_busy t=%0d got=%b exp=%b", m_t, busy, e_busy); end
        end
    endtask

    initial begin
        seg_tbl[0]  = 7'h3F; seg_tbl[1]  = 7'h06; seg_tbl[2]  = 7'h5B; seg_tbl[3]  = 7'h4F;
        seg_tbl[4]  = 7'h66; seg_tbl[5]  = 7'h6D; seg_tbl[6]  = 7'h7D; seg_tbl[7]  = 7'h07;
        seg_tbl[8]  = 7'h7F; seg_tbl[9]  = 7'h6F; seg_tbl[10] = 7'h77; seg_tbl[11] = 7'h7C;
        seg_tbl[12] = 7'h39; seg_tbl[13] = 7'h5E; seg_tbl[14] = 7'h79; seg_tbl[15] = 7'h71;
        m_run = 1'b0; m_t = 0; m_pending = '0; m_active = '0; m_seg = '0;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = 16'h0; lzb = 1'b0;

        test_reset();
        test_basic_scan();
        test_no_tearing();
        test_lzb();
        test_en_drop();
        test_invalid_bcd();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display that shares one external BCD-to-7-segment decoder across all digits. It holds a frame of BCD digits and presents each digit in turn to the shared decoder. It captures the decoded segments and drives one active-low anode at a time, with a dead-time blanking phase between digits to suppress ghosting. It sits between the system's digit/register source and the display pins.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, legal range 2–8.
- REFRESH_DIV, 1000: clock cycles each digit is driven (DRIVE phase length), ≥1.
- DEAD_CYC, 2: blanking cycles before each digit (BLANK phase length), ≥1.
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- en  in  1  scan enable; 0 forces IDLE with display dark.
- load  in  1  one-cycle strobe; captures digits_in into the pending register.
- digits_in  in  4*NUM_DIGITS  BCD digits; digit k = bits [4k+3:4k]; digit 0 = least significant, rightmost.
- lzb  in  1  leading-zero blanking enable.
- bcd_out  out  4  BCD value to the shared decoder input.
- seg_in  in  7  decoder output (a..g), combinational from bcd_out.
- seg_out  out  7  registered segments to the display, same polarity as seg_in.
- an_n  out  NUM_DIGITS  anode enables, active-low, at most one low.
- frame_done  out  1  one-cycle pulse at the end of the last digit's DRIVE phase.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Registers:
  - pending: written by load in any state.
  - active: the frame being displayed.
  - idx: current digit index.
  - cnt: phase counter.
- FSM states: IDLE, BLANK, DRIVE.
- IDLE:
  - an_n all 1, seg_out = 0, idx = 0.
  - On en = 1, go to BLANK for digit 0 (a frame start).
- BLANK:
  - an_n all 1; bcd_out = active digit idx.
  - Lasts DEAD_CYC cycles.
  - On its last cycle, seg_out <= seg_in; then go to DRIVE.
- DRIVE:
  - an_n[idx] = 0, all other anodes 1, unless digit idx is lzb-blanked.
  - A blanked digit keeps all anodes 1 but the phase still runs full length.
  - Lasts REFRESH_DIV cycles.
  - At the end: if idx = NUM_DIGITS-1, pulse frame_done, set idx = 0 and start a new frame in BLANK; else idx+1, go to BLANK.
- Frame start (entry into BLANK for digit 0, from IDLE or a wrap):
  - active <= pending.
  - If load is high in that same cycle, active <= digits_in directly, so a same-cycle load is not lost.
- Leading-zero blanking: digit k (k ≥ 1) is blanked when lzb = 1 and digits k..NUM_DIGITS-1 of active are all 0. Digit 0 is never blanked.
- BCD values 10–15 pass to the decoder unchanged; the decoder output is displayed as is.
- en = 0 in any state: IDLE on the next edge, an_n all 1, seg_out = 0, idx = 0, no frame_done pulse.
- rst_n = 0 overrides en and load.

## Timing
- Reset values:
  - an_n all 1, seg_out 0, bcd_out 0, frame_done 0, busy 0.
  - idx 0, cnt 0, pending 0, active 0, state IDLE.
- The decoder path is combinational. bcd_out is stable for at least DEAD_CYC cycles before seg_out is sampled.
- Digit period = DEAD_CYC + REFRESH_DIV cycles. Frame period = NUM_DIGITS × that.
- From en rising (sampled at edge E): busy = 1 after E. First anode low after E + DEAD_CYC.
- The load-to-display latency is bounded by one frame. active never changes mid-frame (no tearing).
- frame_done is high exactly one cycle, coincident with the last DRIVE cycle of digit NUM_DIGITS-1.
- Reset mid-scan: all outputs reach reset values on the first edge with rst_n = 0.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYC=1.
- Reset: rst_n = 0 for 3 cycles with en = 1 → an_n = 4'b1111, seg_out = 0, busy = 0, frame_done = 0 throughout.
- Basic scan:
  - Stimulus: load digits_in = 16'h1234, then en = 1, decoder model attached.
  - bcd_out sequence: 4, 3, 2, 1.
  - an_n sequence: 1110, 1101, 1011, 0111, each low for 4 cycles with 1 dark cycle between.
  - seg_out matches the decoded digit; frame_done pulses every 20 cycles.
- No tearing: load 16'h5678 mid-frame → the current frame still shows 1234; the next frame shows 5678. A load in the frame-start cycle takes effect in that frame.
- Leading-zero blanking: lzb = 1, digits 16'h0040 → digits 3 and 2 stay dark, digits 1 ('4') and 0 ('0') are lit. Digits 16'h0000 → only digit 0 is lit.
- en drop: en = 0 during DRIVE of digit 2 → next cycle IDLE, an_n = 1111, seg_out = 0, no frame_done. Re-enabling restarts at digit 0.
- Invalid BCD / overlap: digits 16'hFA00 → bcd_out presents 15 and 10 unchanged. an_n never has more than one bit low in any cycle (assertion over the full run).
